// File: rtl/pipe_pkg.sv
// Shared pipeline types: writeback payload bundle and stage occupancy states.
// Imported by pipe_stage and its bench.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic        reg_write;
        logic [1:0]  result_src;
    } memwb_payload_t;

    localparam int unsigned MEMWB_PAYLOAD_W = $bits(memwb_payload_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid flag plus payload register, with load and clear.
// Ports: clk_i, rst_ni, load_i, clear_i (wins over load), data_i -> valid_o, data_o.
module pipe_slot #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    // Clearing only drops the valid flag; the payload keeps its last value
    // so the output never goes X while empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= RESET_VAL;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register stage with optional skid slot (PIPE_STAGE_SKID_EN).
// Ports: clk_i, rst_ni, flush_i, in_valid_i/in_ready_o/in_data_i, out_valid_o/out_ready_i/out_data_o.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned              PAYLOAD_WIDTH = MEMWB_PAYLOAD_W,
    parameter logic [PAYLOAD_WIDTH-1:0] RESET_PAYLOAD = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [PAYLOAD_WIDTH-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [PAYLOAD_WIDTH-1:0] out_data_o
);

    pipe_state_e state_q, state_d;

    logic                     live_q;
    logic                     push;
    logic                     pop;
    logic                     main_v;
    logic [PAYLOAD_WIDTH-1:0] main_d;
    logic [PAYLOAD_WIDTH-1:0] main_din;
    logic                     main_ld;
    logic                     main_clr;
`ifdef PIPE_STAGE_SKID_EN
    logic                     skid_v;
    logic [PAYLOAD_WIDTH-1:0] skid_d;
    logic                     skid_ld;
    logic                     skid_clr;
`endif

    // live_q keeps in_ready_o low through reset and the first edge after it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q  <= 1'b0;
            state_q <= EMPTY;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Registered ready: a full skid slot is exactly state TWO.
    assign in_ready_o = live_q & ~skid_v & ~flush_i;
`else
    assign in_ready_o = live_q & (~main_v | out_ready_i) & ~flush_i;
`endif

    assign push        = in_valid_i & in_ready_o;
    assign pop         = main_v & out_ready_i;
    assign out_valid_o = main_v;
    assign out_data_o  = main_d;

    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        main_din = in_data_i;
`ifdef PIPE_STAGE_SKID_EN
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
`endif
        if (flush_i) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clr = 1'b1;
`endif
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_ld = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_ld = 1'b1;
                    end else if (pop) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (push) begin
                        skid_ld = 1'b1;
                        state_d = TWO;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: begin
                    // Skid beat is older than anything upstream; promote it.
                    if (pop) begin
                        main_ld  = 1'b1;
                        main_din = skid_d;
                        skid_clr = 1'b1;
                        state_d  = ONE;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    pipe_slot #(
        .WIDTH     (PAYLOAD_WIDTH),
        .RESET_VAL (RESET_PAYLOAD)
    ) u_main (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (main_ld),
        .clear_i (main_clr),
        .data_i  (main_din),
        .valid_o (main_v),
        .data_o  (main_d)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_slot #(
        .WIDTH     (PAYLOAD_WIDTH),
        .RESET_VAL ('0)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (skid_ld),
        .clear_i (skid_clr),
        .data_i  (in_data_i),
        .valid_o (skid_v),
        .data_o  (skid_d)
    );
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage; expectations adapt to PIPE_STAGE_SKID_EN.
// Drives inputs 1ns after posedge, samples on negedge.
module tb_pipe_stage;
    import pipe_pkg::*;

    localparam int W = MEMWB_PAYLOAD_W;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] q[$];
        int nxt;
        int got_n;
        int cyc;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_vld", W'(out_valid), W'(0));
        chk("rst_dat", out_data, '0);
        chk("rst_rdy", W'(in_ready), W'(0));
        smp();
        rst_n = 1'b1;
        chk("rst_rdy_rel", W'(in_ready), W'(0));
        smp();
        chk("rdy_after_edge", W'(in_ready), W'(1));

        // Single push, latency 1
        step();
        in_valid = 1'b1; in_data = W'(8'hA5); out_ready = 1'b1;
        smp();
        chk("a5_rdy0", W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        smp();
        chk("a5_vld", W'(out_valid), W'(1));
        chk("a5_dat", out_data, W'(8'hA5));
        chk("a5_rdy1", W'(in_ready), W'(1));
        step();
        smp();
        chk("a5_gone", W'(out_valid), W'(0));

        // Backpressure: 0x11 then 0x22
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h11);
        smp();
        chk("bp_rdy1", W'(in_ready), W'(1));
        step();
        in_data = W'(8'h22);
        smp();
        chk("bp_dat11", out_data, W'(8'h11));
        chk("bp_rdy2", W'(in_ready), W'(SKID ? 0 : 0) | W'(SKID ? 1 : 0));
        step();
        in_valid = ~SKID;
        smp();
        chk("bp_full", W'(in_ready), W'(0));
        chk("bp_hold", out_data, W'(8'h11));
        step();
        out_ready = 1'b1;
        in_valid  = ~SKID;
        smp();
        chk("bp_o11", out_data, W'(8'h11));
        chk("bp_v11", W'(out_valid), W'(1));
        step();
        in_valid = 1'b0;
        smp();
        chk("bp_o22", out_data, W'(8'h22));
        chk("bp_v22", W'(out_valid), W'(1));
        step();
        smp();
        chk("bp_empty", W'(out_valid), W'(0));

        // Full-rate stream 1..100
        for (int i = 1; i <= 100; i++) begin
            step();
            in_valid = 1'b1; in_data = W'(i);
            smp();
            chk("st_rdy", W'(in_ready), W'(1));
            if (i > 1) begin
                chk("st_vld", W'(out_valid), W'(1));
                chk("st_dat", out_data, W'(i - 1));
            end
        end
        step();
        in_valid = 1'b0;
        smp();
        chk("st_last", out_data, W'(100));
        step();
        smp();
        chk("st_done", W'(out_valid), W'(0));

        // Flush with a simultaneous input beat
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h44);
        step();
        in_valid = SKID; in_data = W'(8'h55);
        step();
        flush = 1'b1; in_valid = 1'b1; in_data = W'(8'h33);
        smp();
        chk("fl_rdy", W'(in_ready), W'(0));
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        smp();
        chk("fl_vld", W'(out_valid), W'(0));
        step();
        smp();
        chk("fl_vld2", W'(out_valid), W'(0));
        chk("fl_rdy2", W'(in_ready), W'(1));

        // Asynchronous reset mid-cycle while holding a beat
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h77);
        step();
        in_valid = 1'b0;
        smp();
        chk("ar_vld_pre", W'(out_valid), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", W'(out_valid), W'(0));
        chk("ar_dat", out_data, '0);
        chk("ar_rdy", W'(in_ready), W'(0));
        smp();
        rst_n = 1'b1;
        smp();
        chk("ar_rdy_rel", W'(in_ready), W'(1));
        chk("ar_lost", W'(out_valid), W'(0));

        // Random backpressure with scoreboard
        nxt   = 1;
        got_n = 0;
        cyc   = 0;
        while (got_n < 60 && cyc < 2000) begin
            step();
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (nxt <= 60);
            in_data   = W'(nxt);
            smp();
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_spurious", out_data, '1);
                end else begin
                    chk("sb_dat", out_data, q.pop_front());
                end
                got_n++;
            end
            if (in_valid && in_ready) begin
                q.push_back(W'(nxt));
                nxt++;
            end
            cyc++;
        end
        chk("sb_count", W'(got_n), W'(60));
        chk("sb_drain", W'(q.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 104, meaning the payload bits carried per beat (104 = writeback bundle: alu_result 32, read_data 32, rd 5, pc_plus4 32, reg_write 1, result_src 2).
REQ-002 SHALL have parameter RESET_PAYLOAD, default '0, meaning the value driven on out_data_o after reset.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, meaning an asynchronous, active-low reset.
REQ-005 SHALL have port flush_i, input, 1, meaning a synchronous kill of all held beats.
REQ-006 SHALL have port in_valid_i, input, 1, meaning the upstream beat is valid.
REQ-007 SHALL have port in_ready_o, output, 1, meaning the stage accepts a beat this cycle.
REQ-008 SHALL have port in_data_i, input, PAYLOAD_WIDTH, meaning the upstream payload.
REQ-009 SHALL have port out_valid_o, output, 1, meaning out_data_o holds a valid beat.
REQ-010 SHALL have port out_ready_i, input, 1, meaning downstream consumes the beat this cycle.
REQ-011 SHALL have port out_data_o, output, PAYLOAD_WIDTH, meaning the downstream payload.

Function
REQ-012 SHALL transfer a beat on the input side when in_valid_i && in_ready_o, and on the output side when out_valid_o && out_ready_i.
REQ-013 SHALL present an accepted beat on out_data_o/out_valid_o exactly one cycle after acceptance when the stage was empty (latency 1).
REQ-014 SHALL deliver beats in acceptance order, with no loss or duplication.
REQ-015 SHALL hold out_data_o and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-016 SHALL keep out_data_o unchanged when out_valid_o=0; its content is then don't-care to downstream, but it is not driven X.
REQ-017 SHALL implement states EMPTY (no beat), ONE (main slot full) and TWO (main and skid slots full).
REQ-018 SHALL make these transitions: EMPTY->ONE on push; ONE->EMPTY on pop without push; ONE stays ONE on push+pop; ONE->TWO on push without pop; TWO->ONE on pop, with the skid beat moving to the main slot.
REQ-019 SHALL, when flush_i=1, enter EMPTY on the next edge and discard any simultaneous input beat; flush takes priority over push and pop.
REQ-020 SHALL drive in_ready_o=0 in the cycle in which flush_i=1.
REQ-021 SHALL treat an output beat presented during the flush cycle as consumed if out_ready_i=1; the flush does not retract it.

Reset
REQ-022 SHALL, while rst_ni=0, immediately force state EMPTY, out_valid_o=0, out_data_o=RESET_PAYLOAD, skid slot invalid, and in_ready_o=0.
REQ-023 SHALL raise in_ready_o on the first clk_i edge after rst_ni deasserts; a beat held mid-operation when reset asserts is lost.

Configuration
REQ-024 SHALL, with macro PIPE_STAGE_SKID_EN defined, implement the skid slot, so that in_ready_o = !(state==TWO) is registered, has no combinational path from out_ready_i, and gives full throughput.
REQ-025 SHALL, with PIPE_STAGE_SKID_EN undefined, omit the skid slot and state TWO, so that in_ready_o = !out_valid_o || out_ready_i (combinational), still with full throughput.

Structure
REQ-026 SHALL take from shared package pipe_pkg: typedef memwb_payload_t (packed struct of the six writeback fields), constant MEMWB_PAYLOAD_W = $bits(memwb_payload_t), and the enum pipe_state_e {EMPTY, ONE, TWO}.
REQ-027 SHALL build each storage slot from one sub-module, pipe_slot (valid+data register with load and clear), instantiated once or twice.

Verification
REQ-028 SHALL check: reset, then push 0xA5 with out_ready_i=1 -> out_valid_o=1 and out_data_o=0xA5 on the next cycle, with in_ready_o=1 throughout.
REQ-029 SHALL check: with out_ready_i=0, push 0x11 and then 0x22 (SKID_EN) -> state TWO and in_ready_o=0; set out_ready_i=1 -> 0x11 then 0x22 on consecutive cycles.
REQ-030 SHALL check: continuous push of 1..100 with out_ready_i=1 -> 100 beats out in order, one per cycle, with no bubbles after the first.
REQ-031 SHALL check: in state TWO, flush_i=1 together with in_valid_i=1 and data 0x33 -> next cycle out_valid_o=0, and 0x33 never appears.
REQ-032 SHALL check: rst_ni driven low mid-cycle in state ONE -> out_valid_o=0 and out_data_o=RESET_PAYLOAD before the next edge.
REQ-033 SHALL check: random out_ready_i backpressure (50%) with a scoreboard, run both with and without PIPE_STAGE_SKID_EN -> identical output sequences.
